neuron_mac_unit: RTL and testbench
==================================

// Module: neuron_mac_unit
// PURPOSE
//  Datapath stage downstream of the MLP control unit: multiplies streamed neuron/weight pairs,
//  accumulates one neuron's dot product, applies activation + requantisation, and writes the result
//  to neuron memory at the output neuron address. One result per write_neuron strobe.
//  Sits between the neuron/weight RAM read ports and the neuron RAM write port.
// PARAMETERS
//  DATA_W     8   signed fixed-point width of neuron_in, weight_in, wr_data
//  FRAC_BITS  4   fractional bits of DATA_W format (Q4.4 default)
//  ACC_W      20  signed accumulator width (>= 2*DATA_W)
//  ADDR_W     11  neuron write-address width
// PORTS
//  clk            in   1        rising-edge clock
//  rst            in   1        synchronous, active-high reset
//  mac_en         in   1        neuron_in/weight_in valid this cycle
//  neuron_in      in   DATA_W   signed neuron operand
//  weight_in      in   DATA_W   signed weight operand
//  acc_clear      in   1        discard accumulation (reset_mult_acc from control unit)
//  write_neuron   in   1        finish current neuron, emit result
//  out_addr       in   ADDR_W   output neuron address, sampled with write_neuron
//  wr_en          out  1        neuron RAM write strobe (1-cycle pulse)
//  wr_addr        out  ADDR_W   write address
//  wr_data        out  DATA_W   activated, requantised result
//  busy           out  1        product in flight or accumulation non-empty
//  sat_flag       out  1        sticky: accumulator or output saturated since rst
//  neuron_cnt     out  ADDR_W   results written since rst (wraps modulo 2^ADDR_W)
// BEHAVIOUR
//  Reset: every output 0; prod_q, prod_v, acc, active cleared. rst wins over all other inputs.
//  Stage P (cycle t): mac_en -> prod_q <= neuron_in*weight_in (signed, 2*DATA_W), prod_v <= 1;
//   otherwise prod_v <= 0.
//  Stage A (cycle t+1): acc <= sat_ACC_W(acc + sext(prod_q)) when prod_v; active <= 1.
//   On saturation acc clamps to +/-(2^(ACC_W-1)) limit and sat_flag <= 1.
//  write_neuron at cycle t: final = sat_ACC_W(acc + (prod_v ? prod_q : 0)), i.e. the in-flight
//   product is included. acc <= 0, active <= 0. A mac_en in the same cycle loads stage P normally
//   and belongs to the NEXT neuron (back-to-back neurons without a bubble).
//  Requantise: q = final >>> FRAC_BITS (arithmetic, round toward -inf), then activation/clamp.
//  Output: wr_en=1, wr_addr=out_addr(t), wr_data=q_act at cycle t+1; wr_en=0 otherwise.
//   neuron_cnt increments at t+1. Latency mac_en -> included in result: <= 2 cycles.
//  acc_clear at cycle t (write_neuron=0): acc <= 0, active <= 0, in-flight prod_v dropped
//   (prod_v <= 0 unless mac_en at t reloads it). acc_clear with write_neuron: write result
//   as above, then clear; in-flight product is counted in the result, not dropped.
//  busy = prod_v | active. write_neuron with busy=0 writes q_act of 0.
//  sat_flag also set when requantised value is clamped at output; cleared only by rst.
//  Mid-operation rst: pending result lost, no wr_en issued next cycle.
// CONFIGURATION
//  MAC_RELU_EN defined: q_act = clamp(q, 0, 2^(DATA_W-1)-1); negatives -> 0 (not a saturation).
//  MAC_RELU_EN undefined: linear; q_act = clamp(q, -2^(DATA_W-1), 2^(DATA_W-1)-1).
//  Clamping in either mode at the positive/negative limits sets sat_flag (ReLU zeroing does not).
// TESTING
//  1 Reset: assert rst 2 cycles with mac_en=1 -> wr_en=0, wr_data=0, busy=0, sat_flag=0, cnt=0.
//  2 Dot product: neuron 16 x weights 16,32,-16,8 on 4 cycles, write_neuron on 5th with
//    out_addr=0x041 -> next cycle wr_en=1, wr_addr=0x041, wr_data=40 (640>>>4), cnt=1.
//  3 Negative: 16x-32 then write -> RELU_EN: wr_data=0, sat_flag=0; without: wr_data=-32 (0xE0).
//  4 Overflow: 127x127 x 70 products -> acc clamps at 524287, sat_flag=1, wr_data=127.
//  5 Back-to-back: write_neuron and mac_en (16x16) same cycle, write again 2 cycles later ->
//    first result excludes new product, second wr_data=16; no bubble required.
//  6 acc_clear after 3 products then 16x16 + write -> wr_data=16; rst mid-neuron -> no wr_en.

Source files
------------

// File: rtl/neuron_mac_unit.sv
// Multiply-accumulate stage for one neuron. It applies requantisation and activation, then writes the result to neuron RAM.
// Defining MAC_RELU_EN selects ReLU activation. Leaving it undefined selects a linear activation with signed clamping.
module neuron_mac_unit #(
  parameter int DATA_W    = 8,
  parameter int FRAC_BITS = 4,
  parameter int ACC_W     = 20,
  parameter int ADDR_W    = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mac_en_i,
  input  logic [DATA_W-1:0] neuron_in_i,
  input  logic [DATA_W-1:0] weight_in_i,
  input  logic              acc_clear_i,
  input  logic              write_neuron_i,
  input  logic [ADDR_W-1:0] out_addr_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic              busy_o,
  output logic              sat_flag_o,
  output logic [ADDR_W-1:0] neuron_cnt_o
);

  localparam logic signed [ACC_W:0] AccMax = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] AccMin = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] QMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
`ifndef MAC_RELU_EN
  localparam logic signed [ACC_W-1:0] QMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`endif

  logic signed [2*DATA_W-1:0] prod_q, prod_d;
  logic                       prod_v_q, prod_v_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       active_q, active_d;
  logic                       wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]          wr_data_q, wr_data_d;
  logic                       sat_q, sat_d;
  logic [ADDR_W-1:0]          cnt_q, cnt_d;

  logic signed [ACC_W:0]   addend, sum_wide;
  logic signed [ACC_W-1:0] sum_sat, quant, quant_clamped;
  logic                    acc_ovf, out_clamp;

  // One saturating adder serves both the running accumulation and the final sum.
  // The final sum folds in any product that is still in flight.
  always_comb begin
    addend   = prod_v_q ? {{(ACC_W+1-2*DATA_W){prod_q[2*DATA_W-1]}}, prod_q} : '0;
    sum_wide = {acc_q[ACC_W-1], acc_q} + addend;
    acc_ovf  = 1'b0;
    sum_sat  = sum_wide[ACC_W-1:0];
    if (sum_wide > AccMax) begin
      sum_sat = AccMax[ACC_W-1:0];
      acc_ovf = 1'b1;
    end else if (sum_wide < AccMin) begin
      sum_sat = AccMin[ACC_W-1:0];
      acc_ovf = 1'b1;
    end
    quant         = sum_sat >>> FRAC_BITS;
    quant_clamped = quant;
    out_clamp     = 1'b0;
    if (quant > QMax) begin
      quant_clamped = QMax;
      out_clamp     = 1'b1;
`ifdef MAC_RELU_EN
    end else if (quant[ACC_W-1]) begin
      quant_clamped = '0;
`else
    end else if (quant < QMin) begin
      quant_clamped = QMin;
      out_clamp     = 1'b1;
`endif
    end
  end

  always_comb begin
    prod_d    = prod_q;
    prod_v_d  = mac_en_i;
    acc_d     = acc_q;
    active_d  = active_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    sat_d     = sat_q;
    cnt_d     = cnt_q;
    if (mac_en_i) begin
      prod_d = $signed(neuron_in_i) * $signed(weight_in_i);
    end
    if (write_neuron_i) begin
      acc_d     = '0;
      active_d  = 1'b0;
      wr_en_d   = 1'b1;
      wr_addr_d = out_addr_i;
      wr_data_d = quant_clamped[DATA_W-1:0];
      cnt_d     = cnt_q + ADDR_W'(1);
      sat_d     = sat_q | acc_ovf | out_clamp;
    end else if (acc_clear_i) begin
      acc_d    = '0;
      active_d = 1'b0;
    end else if (prod_v_q) begin
      acc_d    = sum_sat;
      active_d = 1'b1;
      sat_d    = sat_q | acc_ovf;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q    <= '0;
      prod_v_q  <= 1'b0;
      acc_q     <= '0;
      active_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      sat_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      prod_q    <= prod_d;
      prod_v_q  <= prod_v_d;
      acc_q     <= acc_d;
      active_q  <= active_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      sat_q     <= sat_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign busy_o       = prod_v_q | active_q;
  assign sat_flag_o   = sat_q;
  assign neuron_cnt_o = cnt_q;

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Scoreboard bench for neuron_mac_unit. It drives directed vectors, and a monitor checks each RAM write against a queue of expected writes.
module tb_neuron_mac_unit;
  localparam int DATA_W = 8;
  localparam int FRAC_BITS = 4;
  localparam int ACC_W = 20;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst;
  logic              mac_en;
  logic [DATA_W-1:0] neuron_in;
  logic [DATA_W-1:0] weight_in;
  logic              acc_clear;
  logic              write_neuron;
  logic [ADDR_W-1:0] out_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              sat_flag;
  logic [ADDR_W-1:0] neuron_cnt;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] cnt;
    logic              sat;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;
  int   compared = 0;
  int   mismatched = 0;
  int   expCnt = 0;
  logic expSat = 1'b0;

  neuron_mac_unit #(
    .DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .ACC_W(ACC_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .mac_en_i(mac_en), .neuron_in_i(neuron_in),
    .weight_in_i(weight_in), .acc_clear_i(acc_clear), .write_neuron_i(write_neuron),
    .out_addr_i(out_addr), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .busy_o(busy), .sat_flag_o(sat_flag), .neuron_cnt_o(neuron_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs. On a write strobe, it queues the expected RAM write.
  task automatic applyStimulus(input int mac, input int n, input int w, input int clr,
                               input int wn, input int addr, input int expData);
    @(negedge clk);
    mac_en       = mac[0];
    neuron_in    = DATA_W'(n);
    weight_in    = DATA_W'(w);
    acc_clear    = clr[0];
    write_neuron = wn[0];
    out_addr     = ADDR_W'(addr);
    if (wn != 0) begin
      expCnt++;
      expQ.push_back('{addr: ADDR_W'(addr), data: DATA_W'(expData),
                       cnt: ADDR_W'(expCnt), sat: expSat});
    end
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_wr_en", int'(wr_en), 0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_addr", int'(wr_addr), int'(monE.addr));
        checkOutput("wr_data", int'(wr_data), int'(monE.data));
        checkOutput("neuron_cnt", int'(neuron_cnt), int'(monE.cnt));
        checkOutput("sat_flag_at_wr", int'(sat_flag), int'(monE.sat));
      end
    end
  end

  initial begin
    rst = 1'b1; mac_en = 1'b1; neuron_in = 8'd16; weight_in = 8'd16;
    acc_clear = 1'b0; write_neuron = 1'b0; out_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_wr_en", int'(wr_en), 0);
    checkOutput("rst_wr_data", int'(wr_data), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_sat_flag", int'(sat_flag), 0);
    checkOutput("rst_neuron_cnt", int'(neuron_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    mac_en = 1'b0;

    // The dot product 256 + 512 - 256 + 128 = 640 requantises to 40.
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(1, 16, 32, 0, 0, 0, 0);
    applyStimulus(1, 16, -16, 0, 0, 0, 0);
    applyStimulus(1, 16, 8, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 'h041, 40);

`ifdef MAC_RELU_EN
    applyStimulus(1, 16, -32, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 'h042, 0);
`else
    applyStimulus(1, 16, -32, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 'h042, -32);
`endif

    // Back-to-back writes. The product issued with the first write belongs to the second neuron.
    applyStimulus(1, 16, 32, 0, 0, 0, 0);
    applyStimulus(1, 16, 16, 0, 1, 'h043, 32);
    idle();
    applyStimulus(0, 0, 0, 0, 1, 'h044, 16);

    // acc_clear drops both the accumulation and the product that is still in flight.
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("busy_after_clear", int'(busy), 0);
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("busy_product", int'(busy), 1);
    applyStimulus(0, 0, 0, 0, 1, 'h045, 16);
    applyStimulus(0, 0, 0, 0, 1, 'h046, 0);

    // acc_clear together with write_neuron still counts the product that is in flight.
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 'h047, 32);
    applyStimulus(0, 0, 0, 0, 1, 'h048, 0);

    // Positive overflow: 70 x 16129 clamps the accumulator at 524287, which requantises to 32767 and clamps to 127.
    for (int i = 0; i < 70; i++) applyStimulus(1, 127, 127, 0, 0, 0, 0);
    @(posedge clk); #1;
    checkOutput("sat_flag_overflow", int'(sat_flag), 1);
    expSat = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 'h049, 127);

`ifdef MAC_RELU_EN
    for (int i = 0; i < 70; i++) applyStimulus(1, -128, 127, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 'h04A, 0);
`else
    for (int i = 0; i < 70; i++) applyStimulus(1, -128, 127, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 'h04A, -128);
`endif
    idle();

    // A reset asserted in the same cycle as write_neuron loses the pending result.
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    applyStimulus(1, 16, 16, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1; write_neuron = 1'b1; mac_en = 1'b0; out_addr = 11'h050;
    @(posedge clk); #1;
    checkOutput("midrst_wr_en", int'(wr_en), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_cnt", int'(neuron_cnt), 0);
    checkOutput("midrst_sat", int'(sat_flag), 0);
    @(negedge clk);
    rst = 1'b0; write_neuron = 1'b0;
    @(posedge clk); #1;
    checkOutput("postrst_wr_en", int'(wr_en), 0);

    for (int i = 0; i < 10 && expQ.size() != 0; i++) @(posedge clk);
    #2;
    checkOutput("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
